// File: rtl/everloop_pkg.sv
// Shared definitions for the everloop LED serializer: FSM states,
// default WS2812/SK6812 timing at 50 MHz and frame geometry.
package everloop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_ACK,
        ST_SEND,
        ST_LATCH
    } state_t;

    // Default bit timing in 50 MHz clock cycles.
    localparam int unsigned T0H_DEF = 15;    // 0.3 us
    localparam int unsigned T1H_DEF = 30;    // 0.6 us
    localparam int unsigned BIT_DEF = 62;    // 1.25 us
    localparam int unsigned RST_DEF = 4000;  // 80 us latch

    // Frame geometry: 35 RGBW LEDs.
    localparam int unsigned N_LEDS        = 35;
    localparam int unsigned BYTES_PER_LED = 4;
    localparam int unsigned N_BYTES_DEF   = N_LEDS * BYTES_PER_LED;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/everloop_bit_gen.sv
// Single-bit waveform generator: counts one bit period and drives the
// line high for the T0H/T1H portion depending on the bit value.
module everloop_bit_gen
    import everloop_pkg::*;
#(
    parameter int unsigned T0H_CYC = T0H_DEF,
    parameter int unsigned T1H_CYC = T1H_DEF,
    parameter int unsigned BIT_CYC = BIT_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic bit_val,
    output logic line,
    output logic bit_start,
    output logic bit_end
);

    localparam int unsigned CW = cnt_width(BIT_CYC);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HI_ONE   = CW'(T1H_CYC);
    localparam logic [CW-1:0] HI_ZERO  = CW'(T0H_CYC);

    logic [CW-1:0] cnt;

    assign bit_start = run && (cnt == '0);
    assign bit_end   = run && (cnt == LAST_CNT);
    assign line      = run && (cnt < (bit_val ? HI_ONE : HI_ZERO));

    // Bit-period counter: idles at zero, wraps at the end of each bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/everloop_serializer.sv
// Reads one LED frame from the frame RAM and serializes it MSB-first onto
// the single-wire LED data line, followed by the latch low period.
module everloop_serializer
    import everloop_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N_BYTES    = N_BYTES_DEF,
    parameter int unsigned T0H_CYC    = T0H_DEF,
    parameter int unsigned T1H_CYC    = T1H_DEF,
    parameter int unsigned BIT_CYC    = BIT_DEF,
    parameter int unsigned RST_CYC    = RST_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] adr_b,
    output logic                  en_b,
    input  logic [DATA_WIDTH-1:0] dat_b,
    input  logic                  ack_b,
    output logic                  everloop_d,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BW = cnt_width(DATA_WIDTH);
    localparam int unsigned LW = cnt_width(RST_CYC);
    localparam logic [BW-1:0] MSB_IDX  = BW'(DATA_WIDTH - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(RST_CYC - 1);
    localparam logic [LW-1:0] PRE_LAT  = LW'((RST_CYC >= 2) ? RST_CYC - 2 : 0);

    state_t                state;
    logic [ADDR_WIDTH-1:0] byte_idx;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] next_byte;
    logic                  pf_pending;
    logic [LW-1:0]         lat_cnt;

    logic run;
    logic bit_start;
    logic bit_end;
    logic has_next;
    logic has_next2;

    assign run       = (state == ST_SEND);
    assign has_next  = (32'(byte_idx) + 32'd1) < N_BYTES;
    assign has_next2 = (32'(byte_idx) + 32'd2) < N_BYTES;

    everloop_bit_gen #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_gen (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .bit_val   (shift[DATA_WIDTH-1]),
        .line      (everloop_d),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    // Frame FSM with fetch/prefetch and shift register. Read requests are
    // registered one edge early so en_b lands in the first cycle of FETCH
    // and in the first cycle of bit 7 of the byte being sent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            next_byte  <= '0;
            pf_pending <= 1'b0;
            lat_cnt    <= '0;
            adr_b      <= '0;
            en_b       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            en_b <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        adr_b    <= '0;
                        en_b     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_b) begin
                        shift   <= dat_b;
                        bit_idx <= MSB_IDX;
                        state   <= ST_SEND;
                        if (has_next) begin
                            en_b  <= 1'b1;
                            adr_b <= byte_idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (bit_start && (bit_idx == MSB_IDX) && has_next) begin
                        pf_pending <= 1'b1;
                    end
                    if (pf_pending && ack_b) begin
                        next_byte  <= dat_b;
                        pf_pending <= 1'b0;
                    end
                    if (bit_end) begin
                        if (bit_idx == '0) begin
                            if (has_next) begin
                                byte_idx <= byte_idx + ADDR_WIDTH'(1);
                                shift    <= next_byte;
                                bit_idx  <= MSB_IDX;
                                if (has_next2) begin
                                    en_b  <= 1'b1;
                                    adr_b <= byte_idx + ADDR_WIDTH'(2);
                                end
                            end else begin
                                state   <= ST_LATCH;
                                lat_cnt <= '0;
                                done    <= (RST_CYC == 1);
                            end
                        end else begin
                            shift   <= shift << 1;
                            bit_idx <= bit_idx - BW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (lat_cnt == LAST_LAT) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                        done    <= (RST_CYC >= 2) && (lat_cnt == PRE_LAT);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_everloop_serializer.sv
// Self-checking bench: two serializer instances (1-byte and 4-byte frames)
// against an absolute-time waveform model computed from frame contents.
module tb_everloop_serializer;

    localparam int T0H  = 15;
    localparam int T1H  = 30;
    localparam int BIT  = 62;
    localparam int RST1 = 4000;
    localparam int RST4 = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       start_x;
    logic       sel;          // 0: one-byte instance, 1: four-byte instance
    logic       spur;
    int         first_delay;
    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    logic       start1, en1, ack1, d1, busy1, done1, ackq1;
    logic [7:0] adr1, dat1, datq1;
    logic       start4, en4, ack4, d4, busy4, done4, ackq4;
    logic [7:0] adr4, dat4, datq4;

    assign start1 = start_x & ~sel;
    assign start4 = start_x & sel;
    assign ack1   = ackq1 | spur;
    assign dat1   = spur ? 8'hFF : datq1;
    assign ack4   = ackq4;
    assign dat4   = datq4;

    everloop_serializer #(
        .ADDR_WIDTH (8), .DATA_WIDTH (8), .N_BYTES (1),
        .T0H_CYC (T0H), .T1H_CYC (T1H), .BIT_CYC (BIT), .RST_CYC (RST1)
    ) dut1 (
        .clk (clk), .resetn (resetn), .start (start1), .adr_b (adr1),
        .en_b (en1), .dat_b (dat1), .ack_b (ack1), .everloop_d (d1),
        .busy (busy1), .done (done1)
    );

    everloop_serializer #(
        .ADDR_WIDTH (8), .DATA_WIDTH (8), .N_BYTES (4),
        .T0H_CYC (T0H), .T1H_CYC (T1H), .BIT_CYC (BIT), .RST_CYC (RST4)
    ) dut4 (
        .clk (clk), .resetn (resetn), .start (start4), .adr_b (adr4),
        .en_b (en4), .dat_b (dat4), .ack_b (ack4), .everloop_d (d4),
        .busy (busy4), .done (done4)
    );

    // RAM read port models: ack one cycle after en_b, address 0 optionally delayed.
    logic pact1 = 1'b0, pact4 = 1'b0;
    int   pc1 = 0, pc4 = 0;
    logic [7:0] pa1 = '0, pa4 = '0;
    initial begin ackq1 = 1'b0; ackq4 = 1'b0; datq1 = '0; datq4 = '0; end

    always @(posedge clk) begin
        ackq1 <= 1'b0;
        if (pact1) begin
            if (pc1 == 1) begin ackq1 <= 1'b1; datq1 <= mem[pa1]; pact1 <= 1'b0; end
            else pc1 <= pc1 - 1;
        end
        if (en1) begin
            if (adr1 == 8'd0 && first_delay != 0) begin
                pact1 <= 1'b1; pc1 <= first_delay; pa1 <= adr1;
            end else begin
                ackq1 <= 1'b1; datq1 <= mem[adr1];
            end
        end
    end

    always @(posedge clk) begin
        ackq4 <= 1'b0;
        if (pact4) begin
            if (pc4 == 1) begin ackq4 <= 1'b1; datq4 <= mem[pa4]; pact4 <= 1'b0; end
            else pc4 <= pc4 - 1;
        end
        if (en4) begin
            if (adr4 == 8'd0 && first_delay != 0) begin
                pact4 <= 1'b1; pc4 <= first_delay; pa4 <= adr4;
            end else begin
                ackq4 <= 1'b1; datq4 <= mem[adr4];
            end
        end
    end

    logic       od, obusy, odone, oen;
    logic [7:0] oadr;
    always_comb begin
        od    = sel ? d4    : d1;
        obusy = sel ? busy4 : busy1;
        odone = sel ? done4 : done1;
        oen   = sel ? en4   : en1;
        oadr  = sel ? adr4  : adr1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one frame from a start pulse and compares every cycle with the
    // model; abort_at>0 stops sampling just before that cycle.
    task automatic run_frame(input logic s, input int nb, input int rstc,
                             input int dly, input bit poke, input int abort_at,
                             input string tag);
        int first, send_end, done_c, last_k;
        int bad_d, bad_busy, bad_done, bad_en, first_rise, n_done;
        int off, bi, ph, j;
        logic exp_d, exp_en, b;
        logic [7:0] exp_adr;
        sel = s;
        first_delay = dly;
        first    = 3 + dly;
        send_end = first + 8 * nb * BIT;
        done_c   = send_end + rstc - 1;
        last_k   = (abort_at != 0) ? abort_at - 1 : done_c + 2;
        bad_d = 0; bad_busy = 0; bad_done = 0; bad_en = 0;
        first_rise = -1; n_done = 0;
        @(negedge clk);
        start_x = 1'b1;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            start_x = 1'b0;
            exp_d = 1'b0;
            if (k >= first && k < send_end) begin
                off = k - first;
                bi  = off / BIT;
                ph  = off % BIT;
                b   = mem[bi / 8][7 - (bi % 8)];
                exp_d = (ph < (b ? T1H : T0H));
            end
            exp_en = 1'b0;
            exp_adr = '0;
            if (k == 1) begin
                exp_en = 1'b1;
            end else if (k >= first && k < send_end && ((k - first) % (8 * BIT)) == 0) begin
                j = (k - first) / (8 * BIT) + 1;
                if (j < nb) begin
                    exp_en = 1'b1;
                    exp_adr = 8'(j);
                end
            end
            if (od !== exp_d) bad_d++;
            if (obusy !== (k <= done_c)) bad_busy++;
            if (odone !== (k == done_c)) bad_done++;
            if (oen !== exp_en || (exp_en && oadr !== exp_adr)) bad_en++;
            if (od === 1'b1 && first_rise < 0) first_rise = k;
            if (odone === 1'b1) n_done++;
            if (poke && (k == first + 100 || k == send_end + 10 || k == done_c))
                start_x = 1'b1;
        end
        check({tag, "_line"}, bad_d, 0);
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_en_adr"}, bad_en, 0);
        check({tag, "_first_rise"}, first_rise, first);
        if (abort_at == 0) begin
            check({tag, "_done_cycle"}, bad_done, 0);
            check({tag, "_done_count"}, n_done, 1);
        end
    endtask

    int act;

    initial begin
        resetn = 1'b0; start_x = 1'b0; sel = 1'b0; spur = 1'b0; first_delay = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_d1", int'(d1), 0);
        check("rst_busy1", int'(busy1), 0);
        check("rst_done1", int'(done1), 0);
        check("rst_en1", int'(en1), 0);
        check("rst_adr1", int'(adr1), 0);
        check("rst_d4", int'(d4), 0);
        check("rst_busy4", int'(busy4), 0);
        check("rst_en4", int'(en4), 0);
        check("rst_adr4", int'(adr4), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        mem[0] = 8'hA5;
        run_frame(1'b0, 1, RST1, 0, 1'b0, 0, "n1_a5");

        // Spurious acknowledge while idle must not start anything.
        sel = 1'b0;
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        act = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d1 !== 1'b0 || busy1 !== 1'b0 || en1 !== 1'b0 || done1 !== 1'b0) act++;
        end
        check("spur_ack_idle", act, 0);

        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h81; mem[3] = 8'h7E;
        run_frame(1'b1, 4, RST4, 0, 1'b0, 0, "n4_dir");

        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        run_frame(1'b1, 4, RST4, 0, 1'b1, 0, "n4_poke");

        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        run_frame(1'b1, 4, RST4, 3, 1'b0, 0, "n4_dly");

        // Reset in the middle of byte 2, then a fresh frame from address 0.
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        run_frame(1'b1, 4, RST4, 0, 1'b0, 3 + 16 * BIT + 20, "n4_abort");
        resetn = 1'b0;
        #1;
        check("abort_line", int'(d4), 0);
        check("abort_busy", int'(busy4), 0);
        check("abort_en", int'(en4), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_frame(1'b1, 4, RST4, 0, 1'b0, 0, "n4_after_rst");

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
            run_frame(1'b1, 4, RST4, 0, 1'b0, 0, "n4_rand");
        end

        mem[0] = 8'($urandom);
        run_frame(1'b0, 1, RST1, 2, 1'b1, 0, "n1_rand_dly");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
